// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath, with a retired-instruction counter.
// All outputs decode from state, except irwrite/pcwrite in FETCH, which follow mem_ready.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opc,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        pcwritecond,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        irwrite,
    output logic        memtoreg,
    output logic        regdst,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [1:0]  aluop,
    output logic        illegal,
    output logic [15:0] icount
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_REX, S_RWB, S_BEQ, S_IEX, S_IWB, S_JMP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] icount_q, icount_d;
    logic        retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            icount_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_R:             state_d = S_REX;
                    OP_BEQ:           state_d = S_BEQ;
                    OP_ADDI, OP_ANDI: state_d = S_IEX;
                    OP_J:             state_d = S_JMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            // opc is held from DECODE, so only lw/sw can reach here
            S_MEMADR: state_d = (opc == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_REX:    state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_IEX:    state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JMP:    state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = !(opc inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_J});
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_REX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQ: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcsrc       = 2'b01;
                pcwritecond = 1'b1;
            end
            S_IEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = (opc == OP_ANDI) ? 2'b11 : 2'b00;
            end
            S_IWB:   regwrite = 1'b1;
            S_JMP: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: ;
        endcase
    end

    // An instruction retires on the edge that leaves its last state.
    always_comb begin
        retire = (state_q inside {S_MEMWB, S_RWB, S_BEQ, S_IWB, S_JMP}) ||
                 (state_q == S_MEMWR && mem_ready);
        icount_d = retire ? icount_q + 16'd1 : icount_q;
    end

    assign icount = icount_q;
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001: Parameters SHALL be none; all opcodes and encodings below are fixed.
REQ-002: clk  input  1  sole clock, all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: opc  input  6  opcode field from the instruction register, held stable by the datapath from DECODE until the next FETCH.
REQ-005: mem_ready  input  1  memory access completes in the current cycle.
REQ-006: pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca  output  1 each  standard multicycle datapath controls.
REQ-007: alusrcb  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm shifted left 2.
REQ-008: pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009: aluop  output  2  fctrl code to the ALU control decoder: 00 add, 01 sub, 10 use funct field, 11 and.
REQ-010: illegal  output  1  high for the cycle the controller sits in DECODE with an unrecognised opc.
REQ-011: icount  output  16  retired-instruction counter.

Function
REQ-012: The controller SHALL be a Moore FSM; outputs decode from state only, except irwrite/pcwrite in FETCH, which equal mem_ready.
REQ-013: States SHALL be IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ, IEX, IWB, JMP; any output not listed for a state SHALL be 0.
REQ-014: Recognised opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, andi 001100, j 000010.
REQ-015: IDLE: all outputs 0; next FETCH unconditionally.
REQ-016: FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pcwrite=mem_ready; stay until mem_ready=1, then DECODE.
REQ-017: DECODE: alusrca=0, alusrcb=11, aluop=00; next lw/sw->MEMADR, R->REX, beq->BEQ, addi/andi->IEX, j->JMP, other->FETCH with illegal=1.
REQ-018: MEMADR: alusrca=1, alusrcb=10, aluop=00; next lw->MEMRD, sw->MEMWR.
REQ-019: MEMRD: memread=1, iord=1; stay until mem_ready=1, then MEMWB.
REQ-020: MEMWB: regwrite=1, memtoreg=1, regdst=0; next FETCH.
REQ-021: MEMWR: memwrite=1, iord=1; stay until mem_ready=1, then FETCH.
REQ-022: REX: alusrca=1, alusrcb=00, aluop=10; next RWB.  RWB: regwrite=1, regdst=1; next FETCH.
REQ-023: BEQ: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcwritecond=1; next FETCH.
REQ-024: IEX: alusrca=1, alusrcb=10, aluop=00 for addi, 11 for andi; next IWB.  IWB: regwrite=1, regdst=0, memtoreg=0; next FETCH.
REQ-025: JMP: pcwrite=1, pcsrc=10; next FETCH.
REQ-026: icount SHALL increment by 1 on each clock edge leaving MEMWB, MEMWR (with mem_ready), RWB, BEQ, IWB or JMP; never on IDLE->FETCH or illegal DECODE->FETCH; wraps FFFF->0000.
REQ-027: Cycle counts with mem_ready held high: lw 5, sw 4, R 4, addi/andi 4, beq 3, j 3.
REQ-028: mem_ready low SHALL stall only FETCH, MEMRD, MEMWR; it SHALL be ignored in all other states.

Reset
REQ-029: rst_n low SHALL immediately force state IDLE and icount 0000, so every output is 0, regardless of clock or current state, including mid-stall.
REQ-030: After rst_n rises, the first rising edge SHALL move to FETCH.

Verification
REQ-031: Reset, then mem_ready=1, opc=100011 -> states IDLE,FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 and memtoreg=1 only in MEMWB; icount=0001.
REQ-032: opc=000000 -> aluop=10 only in REX, regdst=1 in RWB; opc=001100 -> aluop=11 in IEX; opc=000100 -> aluop=01 and pcwritecond=1 in BEQ.
REQ-033: sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 held 4 cycles, then FETCH; icount increments once.
REQ-034: opc=111111 -> illegal=1 for the single DECODE cycle, next FETCH, icount unchanged.
REQ-035: rst_n asserted mid-MEMRD stall -> all outputs 0 asynchronously, icount=0000; preload 16'hFFFF via 65535 j instructions -> next retire gives 0000.
